// File: rtl/keypad_scanner_if.sv
// Keypad matrix lines plus the key-code/flag pair handed to the controller.
// The scanner takes the master side; the keypad and controller take the slave side.
interface keypad_scanner_if;
   logic [3:0] Col;
   logic [3:0] Row;
   logic [3:0] NumIn;
   logic       Flag;
   logic       KeyValid;

   modport master (input Col, output Row, output NumIn, output Flag, output KeyValid);
   modport slave  (output Col, input Row, input NumIn, input Flag, input KeyValid);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row scan, press/release debounce, and one key code per press.
// Flag stays high while a debounced key is held; NumIn is stable across its falling edge.
module keypad_scanner #(
   parameter int SCAN_DIV = 4,
   parameter int DEB_CNT  = 8
) (
   input  logic             Clk1,
   input  logic             Rst_n,
   keypad_scanner_if.master kp
);

   localparam int CMAX = (SCAN_DIV > DEB_CNT) ? SCAN_DIV : DEB_CNT;
   localparam int CW   = $clog2(CMAX + 1);
   localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_CNT - 1);

   typedef enum logic [1:0] {SCAN, PDEB, HELD, RDEB} state_t;

   state_t        state;
   logic [3:0]    col_meta;
   logic [3:0]    col_s;
   logic [3:0]    cap;
   logic [1:0]    row_idx;
   logic [1:0]    row_next;
   logic [3:0]    row_next_pat;
   logic [CW-1:0] dwell;
   logic [CW-1:0] deb;

   function automatic logic single_low(input logic [3:0] v);
      return (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
   endfunction

   function automatic logic [1:0] col_index(input logic [3:0] v);
      case (v)
         4'b1110: return 2'd0;
         4'b1101: return 2'd1;
         4'b1011: return 2'd2;
         default: return 2'd3;
      endcase
   endfunction

   function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
      case ({r, c})
         4'h0: return 4'd1;
         4'h1: return 4'd2;
         4'h2: return 4'd3;
         4'h3: return 4'd10;
         4'h4: return 4'd4;
         4'h5: return 4'd5;
         4'h6: return 4'd6;
         4'h7: return 4'd11;
         4'h8: return 4'd7;
         4'h9: return 4'd8;
         4'hA: return 4'd9;
         4'hB: return 4'd12;
         4'hC: return 4'd14;
         4'hD: return 4'd0;
         4'hE: return 4'd15;
         default: return 4'd13;
      endcase
   endfunction

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
      return (x == '1) ? x : x + 1'b1;
   endfunction

   always_comb begin
      row_next     = row_idx + 2'd1;
      row_next_pat = ~(4'b0001 << row_next);
   end

   always_ff @(posedge Clk1 or negedge Rst_n) begin
      if (!Rst_n) begin
         col_meta    <= '1;
         col_s       <= '1;
         cap         <= '1;
         state       <= SCAN;
         row_idx     <= '0;
         dwell       <= '0;
         deb         <= '0;
         kp.Row      <= 4'b1110;
         kp.NumIn    <= '0;
         kp.Flag     <= 1'b0;
         kp.KeyValid <= 1'b0;
      end else begin
         col_meta    <= kp.Col;
         col_s       <= col_meta;
         kp.KeyValid <= 1'b0;
         case (state)
            SCAN: begin
               // Sample only on the last dwell cycle so the synchroniser has settled on this row.
               if (dwell == DWELL_LAST) begin
                  dwell <= '0;
                  if (single_low(col_s)) begin
                     cap   <= col_s;
                     deb   <= '0;
                     state <= PDEB;
                  end else begin
                     row_idx <= row_next;
                     kp.Row  <= row_next_pat;
                  end
               end else begin
                  dwell <= sat_inc(dwell);
               end
            end
            PDEB: begin
               if (col_s == cap) begin
                  if (deb == DEB_LAST) begin
                     deb      <= '0;
                     kp.NumIn <= key_code(row_idx, col_index(cap));
                     kp.Flag  <= 1'b1;
                     state    <= HELD;
                  end else begin
                     deb <= sat_inc(deb);
                  end
               end else begin
                  deb     <= '0;
                  row_idx <= row_next;
                  kp.Row  <= row_next_pat;
                  state   <= SCAN;
               end
            end
            HELD: begin
               if (col_s == 4'b1111) begin
                  deb   <= '0;
                  state <= RDEB;
               end
            end
            RDEB: begin
               if (col_s == 4'b1111) begin
                  if (deb == DEB_LAST) begin
                     deb         <= '0;
                     kp.Flag     <= 1'b0;
                     kp.KeyValid <= 1'b1;
                     row_idx     <= row_next;
                     kp.Row      <= row_next_pat;
                     state       <= SCAN;
                  end else begin
                     deb <= sat_inc(deb);
                  end
               end else begin
                  state <= HELD;
               end
            end
            default: state <= SCAN;
         endcase
      end
   end

endmodule
